// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive sequencer.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        BODY,
        OVR
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int          CNT_W         = 11;

    // Byte idx of a MAC address in wire order (idx 0 = most significant byte).
    function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] idx);
        logic [47:0] shifted;
        shifted = addr >> (6'd40 - {idx, 3'b000});
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/eth_byte_counter.sv
// Saturating frame byte counter; clear has priority over increment.
module eth_byte_counter
    import eth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eth_rx_sequencer.sv
// Receive frame sequencer: preamble/SFD detection, dest MAC match, length verdict.
// Define ETH_RX_SEQ_STATS_EN to add saturating good_cnt/err_cnt frame counters.
module eth_rx_sequencer
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int          PRE_MIN  = 7,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             frame_start,
    output logic             frame_good,
    output logic             frame_err,
    output logic             addr_hit,
    output logic [CNT_W-1:0] byte_cnt
`ifdef ETH_RX_SEQ_STATS_EN
    ,
    output logic [7:0]       good_cnt,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [2:0]       PRE_MIN_L = 3'(PRE_MIN);
    localparam logic [CNT_W-1:0] MIN_L     = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_L     = CNT_W'(MAX_LEN);

    state_t     state_reg;
    logic [2:0] pre_cnt_reg;
    logic [2:0] hdr_idx_reg;
    logic       mac_match_reg;
    logic       bc_match_reg;

    logic sfd_ok, cnt_clr, cnt_inc;
    logic frame_end, hdr_abort, len_ok;
    logic good_next, err_next;
    logic mac_byte_eq, bc_byte_eq;

    eth_byte_counter u_byte_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (byte_cnt)
    );

    always_comb begin
        sfd_ok      = (state_reg == PRE) && data_valid && (data_in == SFD_BYTE)
                      && (pre_cnt_reg >= PRE_MIN_L);
        cnt_clr     = sfd_ok;
        cnt_inc     = data_valid && ((state_reg == HDR) || (state_reg == BODY) || (state_reg == OVR));
        frame_end   = !data_valid && ((state_reg == BODY) || (state_reg == OVR));
        hdr_abort   = !data_valid && (state_reg == HDR);
        len_ok      = (byte_cnt >= MIN_L) && (byte_cnt <= MAX_L);
        good_next   = frame_end && len_ok && addr_hit;
        err_next    = hdr_abort || (frame_end && !(len_ok && addr_hit));
        // Running match: each flag stays set only while every dest byte so far agreed.
        mac_byte_eq = mac_match_reg && (data_in == mac_byte(MAC_ADDR, hdr_idx_reg));
        bc_byte_eq  = bc_match_reg && (data_in == mac_byte(BCAST_MAC, hdr_idx_reg));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            pre_cnt_reg   <= '0;
            hdr_idx_reg   <= '0;
            mac_match_reg <= 1'b0;
            bc_match_reg  <= 1'b0;
            frame_start   <= 1'b0;
            frame_good    <= 1'b0;
            frame_err     <= 1'b0;
            addr_hit      <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_good  <= good_next;
            frame_err   <= err_next;
            case (state_reg)
                IDLE: begin
                    if (data_valid && (data_in == PREAMBLE_BYTE)) begin
                        state_reg   <= PRE;
                        pre_cnt_reg <= 3'd1;
                    end else begin
                        pre_cnt_reg <= '0;
                    end
                end
                PRE: begin
                    if (data_valid && (data_in == PREAMBLE_BYTE)) begin
                        pre_cnt_reg <= (pre_cnt_reg == 3'd7) ? 3'd7 : pre_cnt_reg + 3'd1;
                    end else if (sfd_ok) begin
                        state_reg     <= HDR;
                        frame_start   <= 1'b1;
                        hdr_idx_reg   <= '0;
                        mac_match_reg <= 1'b1;
                        bc_match_reg  <= 1'b1;
                        addr_hit      <= 1'b0;
                    end else begin
                        state_reg   <= IDLE;
                        pre_cnt_reg <= '0;
                    end
                end
                HDR: begin
                    if (!data_valid) begin
                        state_reg <= IDLE;
                    end else if (hdr_idx_reg == 3'd5) begin
                        addr_hit  <= mac_byte_eq || bc_byte_eq;
                        state_reg <= BODY;
                    end else begin
                        hdr_idx_reg   <= hdr_idx_reg + 3'd1;
                        mac_match_reg <= mac_byte_eq;
                        bc_match_reg  <= bc_byte_eq;
                    end
                end
                BODY: begin
                    if (!data_valid) begin
                        state_reg <= IDLE;
                    end else if (byte_cnt > MAX_L) begin
                        state_reg <= OVR;
                    end
                end
                OVR: begin
                    if (!data_valid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ETH_RX_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (good_next && (good_cnt != 8'hFF)) begin
                good_cnt <= good_cnt + 8'd1;
            end
            if (err_next && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_sequencer.sv
// Randomized and directed bench for eth_rx_sequencer against a frame-level reference model.
module tb_eth_rx_sequencer;
    import eth_pkg::*;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        frame_start, frame_good, frame_err, addr_hit;
    logic [10:0] byte_cnt;
`ifdef ETH_RX_SEQ_STATS_EN
    logic [7:0]  good_cnt, err_cnt;
`endif

    eth_rx_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .frame_good  (frame_good),
        .frame_err   (frame_err),
        .addr_hit    (addr_hit),
        .byte_cnt    (byte_cnt)
`ifdef ETH_RX_SEQ_STATS_EN
        ,
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state carried between frames.
    int m_cnt = 0;
    int m_hit = 0;
    int m_good_n = 0;
    int m_err_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef ETH_RX_SEQ_STATS_EN
        chk("good_cnt", 32'(good_cnt), 32'(m_good_n));
        chk("err_cnt", 32'(err_cnt), 32'(m_err_n));
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst_out", 32'({frame_start, frame_good, frame_err, addr_hit, byte_cnt}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_cnt = 0; m_hit = 0; m_good_n = 0; m_err_n = 0;
        chk_stats();
    endtask

    // npre x 0x55, optional stray 0x00, SFD, then nbytes frame bytes (dest first), then gap.
    task automatic run_frame(input string tag, input int npre, input bit bad,
                             input logic [47:0] dest, input int nbytes);
        logic [7:0]  q[$];
        logic [47:0] d;
        logic [7:0]  b;
        int sfd_pos, len, ns, ng, ne, spos, vpos;
        bit exp_start, exp_good;
        int exp_cnt, exp_hit;
        for (int i = 0; i < npre; i++) q.push_back(8'h55);
        if (bad) q.push_back(8'h00);
        q.push_back(8'hD5);
        sfd_pos = q.size() - 1;
        for (int i = 0; i < nbytes; i++) begin
            if (i < 6) begin
                d = dest >> (8 * (5 - i));
                q.push_back(d[7:0]);
            end else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h54;
                q.push_back(b);
            end
        end
        len = q.size();
        ns = 0; ng = 0; ne = 0; spos = -1; vpos = -1;
        for (int it = 0; it < len + 4; it++) begin
            @(posedge clk);
            #1;
            if (it < len) begin
                data_valid = 1'b1;
                data_in = q[it];
            end else begin
                data_valid = 1'b0;
                data_in = 8'h00;
            end
            @(negedge clk);
            if (frame_start) begin ns++; spos = it; end
            if (frame_good) begin ng++; vpos = it; end
            if (frame_err) begin ne++; vpos = it; end
        end
        data_valid = 1'b0;

        exp_start = !bad && (npre >= 7);
        if (exp_start) begin
            exp_cnt  = (nbytes > 2047) ? 2047 : nbytes;
            exp_hit  = (nbytes >= 6) && ((dest == MAC) || (dest == BCAST_MAC));
            exp_good = (exp_cnt >= 64) && (exp_cnt <= 1518) && (exp_hit != 0);
            m_cnt = exp_cnt;
            m_hit = exp_hit;
            if (exp_good) m_good_n = (m_good_n == 255) ? 255 : m_good_n + 1;
            else          m_err_n  = (m_err_n == 255) ? 255 : m_err_n + 1;
            chk({tag, ":start_pos"}, 32'(spos), 32'(sfd_pos + 1));
            chk({tag, ":verdict_pos"}, 32'(vpos), 32'(len + 1));
            chk({tag, ":good_n"}, 32'(ng), exp_good ? 32'd1 : 32'd0);
            chk({tag, ":err_n"}, 32'(ne), exp_good ? 32'd0 : 32'd1);
        end else begin
            chk({tag, ":verdicts"}, 32'(ng + ne), 32'd0);
        end
        chk({tag, ":start_n"}, 32'(ns), exp_start ? 32'd1 : 32'd0);
        chk({tag, ":byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
        chk({tag, ":addr_hit"}, 32'(addr_hit), 32'(m_hit));
        chk_stats();
        $display("frame %s pre=%0d bad=%0d dest=%012h n=%0d -> start=%0d good=%0d err=%0d cnt=%0d hit=%0d",
                 tag, npre, bad, dest, nbytes, ns, ng, ne, byte_cnt, addr_hit);
    endtask

    // Good frame interrupted by reset after 30 post-SFD bytes.
    task automatic run_reset_frame();
        logic [47:0] d;
        int ng, ne;
        ng = 0; ne = 0;
        for (int it = 0; it < 8 + 30; it++) begin
            @(posedge clk);
            #1;
            data_valid = 1'b1;
            if (it < 7) data_in = 8'h55;
            else if (it == 7) data_in = 8'hD5;
            else if (it < 14) begin
                d = MAC >> (8 * (13 - it));
                data_in = d[7:0];
            end else data_in = 8'($urandom_range(0, 84));
        end
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out", 32'({frame_start, frame_good, frame_err, addr_hit, byte_cnt}), 32'd0);
        m_cnt = 0; m_hit = 0; m_good_n = 0; m_err_n = 0;
        chk_stats();
        for (int it = 0; it < 6; it++) begin
            @(posedge clk);
            #1;
            if (it == 0) data_valid = 1'b0;
            if (it == 2) reset = 1'b1;
            @(negedge clk);
            if (frame_good) ng++;
            if (frame_err) ne++;
        end
        chk("midrst_verdicts", 32'(ng + ne), 32'd0);
        $display("frame midrst -> verdicts=%0d cnt=%0d", ng + ne, byte_cnt);
    endtask

    initial begin
        logic [47:0] dest;
        int npre, nb, sel;
        bit bad;

        #3;
        chk("rst_out", 32'({frame_start, frame_good, frame_err, addr_hit, byte_cnt}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_frame("t1_good", 7, 1'b0, MAC, 64);
        chk("t1_cnt64", 32'(byte_cnt), 32'd64);
        run_frame("t2_bcast", 7, 1'b0, BCAST_MAC, 64);
        run_frame("t2_miss", 7, 1'b0, 48'h02_00_00_00_00_02, 64);
        chk("t2_miss_hit", 32'(addr_hit), 32'd0);
        run_frame("t3_runt40", 7, 1'b0, MAC, 40);
        run_frame("t3_hdr3", 7, 1'b0, MAC, 3);
        chk("t3_cnt3", 32'(byte_cnt), 32'd3);
        run_frame("t4_1519", 7, 1'b0, MAC, 1519);
        run_frame("t4_1518", 7, 1'b0, MAC, 1518);
        run_frame("t4_sat", 7, 1'b0, MAC, 2100);
        run_frame("t4_min63", 7, 1'b0, MAC, 63);
        run_frame("t5_stray", 3, 1'b1, MAC, 64);
        run_frame("t5_pre6", 6, 1'b0, MAC, 64);
        run_frame("t5_pre7", 7, 1'b0, MAC, 64);
        run_frame("t5_pre10", 10, 1'b0, MAC, 64);
        run_reset_frame();
        run_frame("t6_after", 7, 1'b0, MAC, 64);

        for (int f = 0; f < 40; f++) begin
            npre = $urandom_range(5, 10);
            bad  = ($urandom_range(0, 7) == 0);
            sel  = $urandom_range(0, 2);
            if (sel == 0) dest = MAC;
            else if (sel == 1) dest = BCAST_MAC;
            else dest = MAC ^ (48'd1 << $urandom_range(0, 47));
            sel = $urandom_range(0, 3);
            if (sel == 0) nb = $urandom_range(0, 5);
            else if (sel == 1) nb = $urandom_range(6, 63);
            else if (sel == 2) nb = $urandom_range(64, 300);
            else nb = $urandom_range(1510, 1530);
            run_frame($sformatf("rnd%0d", f), npre, bad, dest, nb);
        end

`ifdef ETH_RX_SEQ_STATS_EN
        do_reset();
        for (int f = 0; f < 300; f++) run_frame("t7_good", 7, 1'b0, MAC, 64);
        run_frame("t7_runt", 7, 1'b0, MAC, 40);
        run_frame("t7_runt", 7, 1'b0, MAC, 40);
        chk("t7_good255", 32'(good_cnt), 32'd255);
        chk("t7_err2", 32'(err_cnt), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
